// File: rtl/mymod_stim_pkg.sv
// Shared types and constants for the myMod stimulus sequencer.
// Optional MISR signature is enabled by defining MYMOD_STIM_SIG_EN.
package mymod_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [1:0]  SI_LAST   = 2'b11;

endpackage

// File: rtl/mymod_misr.sv
// 16-bit MISR compressing one B_W-bit word per enabled cycle; clr wins over en.
// Only instantiated when MYMOD_STIM_SIG_EN is defined.
module mymod_misr #(
    parameter int          B_W  = 8,
    parameter logic [15:0] POLY = 16'h1021
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [B_W-1:0] din,
    output logic [15:0]    sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;
    logic [15:0] din_ext;

    always_comb begin
        din_ext = '0;
        din_ext[B_W-1:0] = din;
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ din_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/mymod_stim_seq.sv
// On-chip sweep initiator for myMod: walks A over its full range with (S,I)=00..11 per value.
// Define MYMOD_STIM_SIG_EN to compress the sampled B values into a 16-bit MISR signature.
//
// Handshake: start is a one-cycle request taken only in IDLE or DONE; abort wins over start
// in any state; sample marks the single cycle in which B is expected to be valid.
module mymod_stim_seq
    import mymod_stim_pkg::*;
#(
    parameter int A_W      = 5,
    parameter int B_W      = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           start,
    input  logic           abort,
    output logic [A_W-1:0] A,
    output logic           S,
    output logic           I,
    input  logic [B_W-1:0] B,
    output logic           busy,
    output logic           sample,
    output logic           done,
    output logic [15:0]    sig,
    output state_e         dbg_state
);

    localparam int              HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [A_W-1:0]  A_MAX     = '1;

    state_e         state_q, state_d;
    logic [A_W-1:0] a_q, a_d;
    logic [1:0]     si_q, si_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           start_acc;
    logic           last_hold;

    assign last_hold = (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        si_d      = si_q;
        hold_d    = hold_q;
        start_acc = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    a_d       = '0;
                    si_d      = '0;
                    hold_d    = '0;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (last_hold) begin
                    hold_d = '0;
                    // The final step parks A/S/I so DONE shows the last operand.
                    if ((a_q == A_MAX) && (si_q == SI_LAST)) begin
                        state_d = DONE;
                    end else begin
                        si_d = si_q + 2'd1;
                        if (si_q == SI_LAST) begin
                            a_d = a_q + 1'b1;
                        end
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d   = IDLE;
            a_d       = '0;
            si_d      = '0;
            hold_d    = '0;
            start_acc = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            si_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            si_q    <= si_d;
            hold_q  <= hold_d;
        end
    end

    assign A         = a_q;
    assign S         = si_q[1];
    assign I         = si_q[0];
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sample    = (state_q == RUN) && last_hold;
    assign dbg_state = state_q;

`ifdef MYMOD_STIM_SIG_EN
    // Abort must leave the signature untouched, even on a sample cycle.
    mymod_misr #(
        .B_W  (B_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk (Clk),
        .rst (Rst),
        .clr (start_acc),
        .en  (sample && !abort),
        .din (B),
        .sig (sig)
    );
`else
    logic unused_b;
    logic unused_start_acc;
    assign unused_b         = ^B;
    assign unused_start_acc = start_acc;
    assign sig              = 16'h0000;
`endif

endmodule
